// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with hardwired x0, same-cycle write bypass,
// a second (cache-fill) write port and a per-register load-miss scoreboard.
// Ports:
//   CLK, RESETN (async active-low);
//   RADDR/RDATA/RBUSY (NRD combinational read ports, bypassed);
//   WEN/WADDR/WDATA (primary write);
//   PEND_SET/PEND_ADDR (mark load miss);
//   FILL_EN/FILL_ADDR/FILL_DATA (refill write, clears pending);
//   PEND_CNT/PEND_FULL/PEND_ERR (scoreboard status);
//   DBG_ADDR/DBG_DATA (stored state, no bypass).
module reg_file_sb #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int AW      = $clog2(NREG),
  parameter int NRD     = 2,
  parameter int MAXPEND = 4,
  parameter int CW      = $clog2(MAXPEND + 1)
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic [NRD*AW-1:0]   RADDR,
  output logic [NRD*XLEN-1:0] RDATA,
  output logic [NRD-1:0]      RBUSY,
  input  logic                WEN,
  input  logic [AW-1:0]       WADDR,
  input  logic [XLEN-1:0]     WDATA,
  input  logic                PEND_SET,
  input  logic [AW-1:0]       PEND_ADDR,
  input  logic                FILL_EN,
  input  logic [AW-1:0]       FILL_ADDR,
  input  logic [XLEN-1:0]     FILL_DATA,
  output logic [CW-1:0]       PEND_CNT,
  output logic                PEND_FULL,
  output logic                PEND_ERR,
  input  logic [AW-1:0]       DBG_ADDR,
  output logic [XLEN-1:0]     DBG_DATA
);

  localparam logic [CW-1:0] MAXP = CW'(MAXPEND);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic fill_nz, fill_acc, fill_err;
  logic set_nz, free_first, set_ok, set_err;

  // Writes to x0 on any port are silently dropped, so every qualifier
  // below starts from a nonzero-address check.
  assign fill_nz  = FILL_EN && (FILL_ADDR != '0);
  assign fill_acc = fill_nz && pend_q[FILL_ADDR];
  assign fill_err = fill_nz && !pend_q[FILL_ADDR];

  // An accepted fill to the same register frees its slot first, so a
  // re-issued miss is accepted even if the register was pending or the
  // scoreboard was full (the net count does not change).
  assign set_nz     = PEND_SET && (PEND_ADDR != '0);
  assign free_first = fill_acc && (FILL_ADDR == PEND_ADDR);
  assign set_ok     = set_nz && (free_first || (!pend_q[PEND_ADDR] && (cnt_q < MAXP)));
  assign set_err    = set_nz && !set_ok;

  always_comb begin
    pend_d = pend_q;
    if (fill_acc) pend_d[FILL_ADDR] = 1'b0;
    // Set after clear: a new miss wins over a same-cycle fill.
    if (set_ok)   pend_d[PEND_ADDR] = 1'b1;
    cnt_d = cnt_q + CW'(set_ok) - CW'(fill_acc);
    err_d = err_q | set_err | fill_err;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (fill_nz) regs_q[FILL_ADDR] <= FILL_DATA;
      // Later assignment wins: primary write data beats fill data.
      if (WEN && (WADDR != '0)) regs_q[WADDR] <= WDATA;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rd;
    logic            fill_hit;

    assign addr     = RADDR[g*AW +: AW];
    assign fill_hit = FILL_EN && (FILL_ADDR == addr);

    // Priority: x0, then primary write, then fill, then stored value.
    always_comb begin
      rd = regs_q[addr];
      if (fill_hit)                 rd = FILL_DATA;
      if (WEN && (WADDR == addr))   rd = WDATA;
      if (addr == '0)               rd = '0;
    end

    assign RDATA[g*XLEN +: XLEN] = rd;
    // pend_q[0] is never set, so x0 is never busy.
    assign RBUSY[g] = pend_q[addr] && !fill_hit;
  end

  assign PEND_CNT  = cnt_q;
  assign PEND_FULL = (cnt_q == MAXP);
  assign PEND_ERR  = err_q;
  assign DBG_DATA  = regs_q[DBG_ADDR];

endmodule
